// File: rtl/weight_serializer.sv
// Parallel-to-serial weight feeder for the bit-serial multiplier, with a one-word
// pending buffer so consecutive words stream with no idle cycle between them.
module weight_serializer #(
    parameter int WIDTH     = 16,
    parameter int NWIDTH    = 16,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              w_valid,
    output logic              w_ready,
    input  logic [WIDTH-1:0]  w_data,
    input  logic [NWIDTH-1:0] neuron_in,
    input  logic              stall,
    output logic              weight_bit,
    output logic [NWIDTH-1:0] neuron_out,
    output logic              mult_enable,
    output logic              mult_start,
    output logic              mult_last,
    output logic              busy,
    output logic [15:0]       word_count
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t             state_reg, state_next;
    logic [WIDTH-1:0]   shift_reg, shift_next;
    logic [NWIDTH-1:0]  neuron_reg, neuron_next;
    logic [CW-1:0]      cnt_reg, cnt_next;
    logic [WIDTH-1:0]   pend_word_reg, pend_word_next;
    logic [NWIDTH-1:0]  pend_neuron_reg, pend_neuron_next;
    logic               pend_full_reg, pend_full_next;
    logic [15:0]        word_count_reg, word_count_next;
    logic [WIDTH-1:0]   shift_step;
    logic               accept;

    assign accept = w_valid & w_ready;

    generate
        if (MSB_FIRST) begin : g_msb
            assign shift_step = shift_reg << 1;
            assign weight_bit = shift_reg[WIDTH-1];
        end else begin : g_lsb
            assign shift_step = shift_reg >> 1;
            assign weight_bit = shift_reg[0];
        end
    endgenerate

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = SHIFT;
            SHIFT:   if (mult_last && !pend_full_reg && !accept) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        mult_enable = 1'b0;
        mult_start  = 1'b0;
        mult_last   = 1'b0;
        if (state_reg == SHIFT && !stall) begin
            mult_enable = 1'b1;
            mult_start  = (cnt_reg == '0);
            mult_last   = (cnt_reg == LAST_IDX);
        end
    end

    assign w_ready    = ~pend_full_reg;
    assign busy       = (state_reg == SHIFT) | pend_full_reg;
    assign neuron_out = neuron_reg;
    assign word_count = word_count_reg;

    // Datapath next values
    always_comb begin
        shift_next       = shift_reg;
        neuron_next      = neuron_reg;
        cnt_next         = cnt_reg;
        pend_word_next   = pend_word_reg;
        pend_neuron_next = pend_neuron_reg;
        pend_full_next   = pend_full_reg;
        word_count_next  = word_count_reg;

        if (state_reg == IDLE) begin
            if (accept) begin
                shift_next  = w_data;
                neuron_next = neuron_in;
                cnt_next    = '0;
            end
        end else if (mult_last) begin
            word_count_next = word_count_reg + 16'd1;
            if (pend_full_reg) begin
                shift_next     = pend_word_reg;
                neuron_next    = pend_neuron_reg;
                cnt_next       = '0;
                pend_full_next = 1'b0;
            end else if (accept) begin
                shift_next  = w_data;
                neuron_next = neuron_in;
                cnt_next    = '0;
            end
        end else begin
            if (mult_enable) begin
                shift_next = shift_step;
                cnt_next   = cnt_reg + 1'b1;
            end
            // Pending capture is allowed even while stalled.
            if (accept) begin
                pend_word_next   = w_data;
                pend_neuron_next = neuron_in;
                pend_full_next   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shift_reg       <= '0;
            neuron_reg      <= '0;
            cnt_reg         <= '0;
            pend_word_reg   <= '0;
            pend_neuron_reg <= '0;
            pend_full_reg   <= 1'b0;
            word_count_reg  <= '0;
        end else begin
            shift_reg       <= shift_next;
            neuron_reg      <= neuron_next;
            cnt_reg         <= cnt_next;
            pend_word_reg   <= pend_word_next;
            pend_neuron_reg <= pend_neuron_next;
            pend_full_reg   <= pend_full_next;
            word_count_reg  <= word_count_next;
        end
    end

endmodule

// File: tb/tb_weight_serializer.sv
// Self-checking bench for weight_serializer: scoreboard of expected serial bits checked
// every falling edge, plus directed checks for reset, pending, stall and MSB-first order.
module tb_weight_serializer;

    logic        clk = 1'b0;
    logic        reset;
    logic        w_valid;
    logic        w_ready;
    logic [15:0] w_data;
    logic [15:0] neuron_in;
    logic        stall;
    logic        weight_bit;
    logic [15:0] neuron_out;
    logic        mult_enable, mult_start, mult_last, busy;
    logic [15:0] word_count;

    logic        m_w_valid, m_w_ready;
    logic [15:0] m_w_data, m_neuron_in, m_neuron_out, m_word_count;
    logic        m_weight_bit, m_mult_enable, m_mult_start, m_mult_last, m_busy;

    typedef struct packed {
        logic        b;
        logic [15:0] n;
        logic        s;
        logic        l;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_wc = 16'd0;
    bit          mon_en = 1'b0;

    always #5 clk = ~clk;

    weight_serializer #(.WIDTH(16), .NWIDTH(16), .MSB_FIRST(1'b0)) dut (
        .clk(clk), .reset(reset), .w_valid(w_valid), .w_ready(w_ready),
        .w_data(w_data), .neuron_in(neuron_in), .stall(stall),
        .weight_bit(weight_bit), .neuron_out(neuron_out),
        .mult_enable(mult_enable), .mult_start(mult_start), .mult_last(mult_last),
        .busy(busy), .word_count(word_count)
    );

    weight_serializer #(.WIDTH(16), .NWIDTH(16), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .reset(reset), .w_valid(m_w_valid), .w_ready(m_w_ready),
        .w_data(m_w_data), .neuron_in(m_neuron_in), .stall(1'b0),
        .weight_bit(m_weight_bit), .neuron_out(m_neuron_out),
        .mult_enable(m_mult_enable), .mult_start(m_mult_start), .mult_last(m_mult_last),
        .busy(m_busy), .word_count(m_word_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic push_word(input logic [15:0] w, input logic [15:0] n);
        exp_t e;
        for (int i = 0; i < 16; i++) begin
            e.b = w[i];
            e.n = n;
            e.s = (i == 0);
            e.l = (i == 15);
            q.push_back(e);
        end
    endtask

    // Drives one word and returns one time unit after the accepting edge.
    task automatic send(input logic [15:0] w, input logic [15:0] n);
        logic acc;
        acc       = 1'b0;
        w_valid   = 1'b1;
        w_data    = w;
        neuron_in = n;
        for (int k = 0; k < 64 && !acc; k++) begin
            acc = w_ready;
            @(posedge clk);
            if (acc) push_word(w, n);
            #1;
        end
        w_valid = 1'b0;
        $display("send w=%04h n=%04h accepted=%0b", w, n, acc);
        check("accept", {31'd0, acc}, 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
        check(tag, {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        exp_t e;
        logic exp_en;
        if (mon_en && !reset) begin
            exp_en = (q.size() != 0) && !stall;
            check("mult_enable", {31'd0, mult_enable}, {31'd0, exp_en});
            check("word_count", {16'd0, word_count}, {16'd0, exp_wc});
            if (mult_enable && q.size() != 0) begin
                e = q.pop_front();
                check("weight_bit", {31'd0, weight_bit}, {31'd0, e.b});
                check("neuron_out", {16'd0, neuron_out}, {16'd0, e.n});
                check("mult_start", {31'd0, mult_start}, {31'd0, e.s});
                check("mult_last", {31'd0, mult_last}, {31'd0, e.l});
                if (e.l) exp_wc = exp_wc + 16'd1;
            end
        end
    end

    initial begin
        int n;
        reset     = 1'b1;
        w_valid   = 1'b0;
        w_data    = '0;
        neuron_in = '0;
        stall     = 1'b0;
        m_w_valid = 1'b0;
        m_w_data  = '0;
        m_neuron_in = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_weight_bit", {31'd0, weight_bit}, 32'd0);
        check("rst_neuron_out", {16'd0, neuron_out}, 32'd0);
        check("rst_enable", {29'd0, mult_enable, mult_start, mult_last}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_w_ready", {31'd0, w_ready}, 32'd1);
        check("rst_word_count", {16'd0, word_count}, 32'd0);
        mon_en = 1'b1;

        // Single word from IDLE
        send(16'h1111, 16'h6160);
        wait_idle("idle_after_1111");
        check("wc_after_1111", {16'd0, word_count}, 32'd1);

        // Back-to-back via pending buffer
        send(16'h8001, 16'h1234);
        send(16'hFFFF, 16'hABCD);
        check("pend_w_ready", {31'd0, w_ready}, 32'd0);
        check("pend_busy", {31'd0, busy}, 32'd1);
        wait_idle("idle_after_pair");
        check("wc_after_pair", {16'd0, word_count}, 32'd3);

        // Stall for 3 cycles while cnt=5
        send(16'h0020, 16'h5A5A);
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            check("stall_hold_bit", {31'd0, weight_bit}, 32'd1);
            @(posedge clk);
            #1;
        end
        stall = 1'b0;
        n = 8;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (busy) n++;
            else break;
        end
        $display("stalled word busy cycles=%0d", n);
        check("stall_word_cycles", n, 32'd19);
        @(posedge clk);
        #1;

        // Reset mid-word with a pending word
        send(16'h00FF, 16'h1111);
        send(16'hF0F0, 16'h2222);
        repeat (6) begin
            @(posedge clk);
            #1;
        end
        check("pre_reset_w_ready", {31'd0, w_ready}, 32'd0);
        reset = 1'b1;
        q.delete();
        exp_wc = 16'd0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("abort_w_ready", {31'd0, w_ready}, 32'd1);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_word_count", {16'd0, word_count}, 32'd0);
        check("abort_enable", {31'd0, mult_enable}, 32'd0);
        repeat (5) begin
            @(posedge clk);
            #1;
        end

        // MSB-first instance
        m_w_valid   = 1'b1;
        m_w_data    = 16'h8000;
        m_neuron_in = 16'hC0DE;
        check("m_w_ready", {31'd0, m_w_ready}, 32'd1);
        @(posedge clk);
        #1;
        m_w_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            $display("msb cycle %0d bit=%0b en=%0b", i, m_weight_bit, m_mult_enable);
            check("m_weight_bit", {31'd0, m_weight_bit}, (i == 0) ? 32'd1 : 32'd0);
            check("m_enable", {31'd0, m_mult_enable}, 32'd1);
            check("m_start", {31'd0, m_mult_start}, (i == 0) ? 32'd1 : 32'd0);
        end
        @(negedge clk);
        check("m_enable_done", {31'd0, m_mult_enable}, 32'd0);
        check("m_word_count", {16'd0, m_word_count}, 32'd1);

        @(posedge clk);
        #1;
        check("scoreboard_empty", q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
